// File: rtl/arm_pkg.sv
// Shared constants, FSM encoding and condition evaluation for the ARM data-processing core.
package arm_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic {
        StFetch = 1'b0,
        StExec  = 1'b1
    } state_t;

    // NV never passes; the core flags it as undefined separately.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_shifter.sv
// Barrel shifter for operand 2: rotated immediates and immediate-shifted registers.
module arm_shifter
    import arm_pkg::*;
(
    input  logic [31:0] i_value,
    input  logic [4:0]  i_amount,
    input  logic [1:0]  i_type,
    input  logic        i_imm_mode,
    input  logic        i_carry_in,
    output logic [31:0] o_result,
    output logic        o_carry
);

    logic [31:0] w_ror;
    logic [32:0] w_lsl;
    logic [32:0] w_lsr;
    logic [32:0] w_asr;

    // Extra bit on each shift captures the last bit shifted out.
    assign w_ror = (i_value >> i_amount) | (i_value << (6'd32 - {1'b0, i_amount}));
    assign w_lsl = {1'b0, i_value} << i_amount;
    assign w_lsr = {i_value, 1'b0} >> i_amount;
    assign w_asr = $signed({i_value, 1'b0}) >>> i_amount;

    // Select result and carry, including the amount-zero encodings.
    always_comb begin
        o_result = w_ror;
        o_carry  = i_carry_in;
        if (i_imm_mode) begin
            o_result = w_ror;
            o_carry  = (i_amount == 5'd0) ? i_carry_in : w_ror[31];
        end else begin
            case (i_type)
                SH_LSL: begin
                    if (i_amount == 5'd0) begin
                        o_result = i_value;
                        o_carry  = i_carry_in;
                    end else begin
                        o_result = w_lsl[31:0];
                        o_carry  = w_lsl[32];
                    end
                end
                SH_LSR: begin
                    if (i_amount == 5'd0) begin
                        o_result = 32'h0;
                        o_carry  = i_value[31];
                    end else begin
                        o_result = w_lsr[32:1];
                        o_carry  = w_lsr[0];
                    end
                end
                SH_ASR: begin
                    if (i_amount == 5'd0) begin
                        o_result = {32{i_value[31]}};
                        o_carry  = i_value[31];
                    end else begin
                        o_result = w_asr[32:1];
                        o_carry  = w_asr[0];
                    end
                end
                SH_ROR: begin
                    if (i_amount == 5'd0) begin
                        o_result = {i_carry_in, i_value[31:1]};
                        o_carry  = i_value[0];
                    end else begin
                        o_result = w_ror;
                        o_carry  = w_ror[31];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/arm_dp_core.sv
// Multi-cycle ARMv4 core: all data-processing opcodes plus B/BL, FETCH/EXEC sequencing.
module arm_dp_core
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_running,
    output logic        o_fetch_req,
    output logic [31:0] o_fetch_addr,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_data,
    input  logic [3:0]  i_dbg_sel,
    output logic [31:0] o_dbg_data,
    output logic [3:0]  o_flags,
    output logic        o_retire,
    output logic        o_undef
);

    state_t      r_state, w_state_next;
    logic [31:0] r_regs [15];
    logic [31:0] r_pc, r_insn;
    logic [3:0]  r_nzcv;
    logic        r_req_held, r_post_reset;
    logic        w_fetch_req, w_retire;

    logic [3:0]  w_cond, w_opcode, w_rn, w_rd, w_rm;
    logic        w_imm, w_s, w_is_test, w_is_dp, w_is_branch, w_undef, w_exec;
    logic [31:0] w_pc4, w_pc8, w_rn_val, w_rm_val, w_op2, w_result, w_br_target, w_pc_next;
    logic        w_sh_carry, w_is_arith, w_alu_c, w_alu_v;
    logic        w_wr_en, w_flag_en, w_bl_en, w_pc_wr;
    logic [3:0]  w_nzcv_next;

    assign w_cond    = r_insn[31:28];
    assign w_imm     = r_insn[25];
    assign w_opcode  = r_insn[24:21];
    assign w_s       = r_insn[20];
    assign w_rn      = r_insn[19:16];
    assign w_rd      = r_insn[15:12];
    assign w_rm      = r_insn[3:0];
    assign w_pc4     = r_pc + 32'd4;
    assign w_pc8     = r_pc + 32'd8;

    assign w_is_test   = (w_opcode[3:2] == 2'b10);
    assign w_is_dp     = (r_insn[27:26] == 2'b00) && (r_insn[7:4] != 4'b1001)
                         && !(!w_imm && r_insn[4]) && !(w_is_test && !w_s);
    assign w_is_branch = (r_insn[27:25] == 3'b101);
    assign w_undef     = (w_cond == COND_NV) || !(w_is_dp || w_is_branch);
    assign w_exec      = !w_undef && cond_pass(w_cond, r_nzcv);

    assign w_rn_val = (w_rn == 4'd15) ? w_pc8 : r_regs[w_rn];
    assign w_rm_val = (w_rm == 4'd15) ? w_pc8 : r_regs[w_rm];

    arm_shifter u_shifter (
        .i_value    (w_imm ? {24'h0, r_insn[7:0]} : w_rm_val),
        .i_amount   (w_imm ? {r_insn[11:8], 1'b0} : r_insn[11:7]),
        .i_type     (w_imm ? SH_ROR : r_insn[6:5]),
        .i_imm_mode (w_imm),
        .i_carry_in (r_nzcv[1]),
        .o_result   (w_op2),
        .o_carry    (w_sh_carry)
    );

    // ALU: subtract forms are a + ~b + carry-in, so C falls out as NOT borrow.
    always_comb begin
        logic [31:0] a, b;
        logic        cin;
        logic [32:0] sum;
        a          = w_rn_val;
        b          = w_op2;
        cin        = 1'b0;
        w_is_arith = 1'b0;
        w_result   = 32'h0;
        case (w_opcode)
            OP_AND, OP_TST: w_result = w_rn_val & w_op2;
            OP_EOR, OP_TEQ: w_result = w_rn_val ^ w_op2;
            OP_ORR:         w_result = w_rn_val | w_op2;
            OP_MOV:         w_result = w_op2;
            OP_BIC:         w_result = w_rn_val & ~w_op2;
            OP_MVN:         w_result = ~w_op2;
            OP_SUB, OP_CMP: begin w_is_arith = 1'b1; b = ~w_op2; cin = 1'b1; end
            OP_RSB: begin w_is_arith = 1'b1; a = w_op2; b = ~w_rn_val; cin = 1'b1; end
            OP_ADD, OP_CMN: w_is_arith = 1'b1;
            OP_ADC: begin w_is_arith = 1'b1; cin = r_nzcv[1]; end
            OP_SBC: begin w_is_arith = 1'b1; b = ~w_op2; cin = r_nzcv[1]; end
            OP_RSC: begin w_is_arith = 1'b1; a = w_op2; b = ~w_rn_val; cin = r_nzcv[1]; end
            default: ;
        endcase
        sum     = {1'b0, a} + {1'b0, b} + {32'h0, cin};
        w_alu_c = sum[32];
        w_alu_v = (a[31] == b[31]) && (sum[31] != a[31]);
        if (w_is_arith) begin
            w_result = sum[31:0];
        end
    end

    assign w_nzcv_next = {w_result[31], (w_result == 32'h0),
                          w_is_arith ? w_alu_c : w_sh_carry,
                          w_is_arith ? w_alu_v : r_nzcv[0]};

    assign w_wr_en     = w_exec && w_is_dp && !w_is_test && (w_rd != 4'd15);
    assign w_pc_wr     = w_exec && w_is_dp && !w_is_test && (w_rd == 4'd15);
    assign w_flag_en   = w_exec && w_is_dp && w_s;
    assign w_bl_en     = w_exec && w_is_branch && r_insn[24];
    assign w_br_target = w_pc8 + {{6{r_insn[23]}}, r_insn[23:0], 2'b00};
    assign w_pc_next   = (w_exec && w_is_branch) ? w_br_target :
                         w_pc_wr ? {w_result[31:2], 2'b00} : w_pc4;

    // Architectural state: written only on the edge that ends EXEC.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= 32'h0;
            end
            r_pc   <= RESET_PC;
            r_nzcv <= 4'h0;
        end else if (r_state == StExec) begin
            r_pc <= w_pc_next;
            if (w_wr_en) begin
                r_regs[w_rd] <= w_result;
            end
            if (w_bl_en) begin
                r_regs[14] <= w_pc4;
            end
            if (w_flag_en) begin
                r_nzcv <= w_nzcv_next;
            end
        end
    end

    // FSM state, held request and latched instruction.
    always_ff @(posedge clk) begin
        r_post_reset <= i_reset;
        if (i_reset) begin
            r_state    <= StFetch;
            r_req_held <= 1'b0;
            r_insn     <= 32'h0;
        end else begin
            r_state    <= w_state_next;
            r_req_held <= (r_state == StFetch) && w_fetch_req && !i_fetch_valid;
            if ((r_state == StFetch) && w_fetch_req && i_fetch_valid) begin
                r_insn <= i_fetch_data;
            end
        end
    end

    // Next state and handshake; the request stays up once issued, regardless of i_running.
    always_comb begin
        w_state_next = r_state;
        w_fetch_req  = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            StFetch: begin
                w_fetch_req = !r_post_reset && (i_running || r_req_held);
                if (w_fetch_req && i_fetch_valid) begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                w_retire     = 1'b1;
                w_state_next = StFetch;
            end
            default: w_state_next = StFetch;
        endcase
    end

    assign o_fetch_req  = w_fetch_req && !i_reset;
    assign o_fetch_addr = r_pc;
    assign o_retire     = w_retire && !i_reset;
    assign o_undef      = w_retire && w_undef && !i_reset;
    assign o_flags      = r_nzcv;
    assign o_dbg_data   = (i_dbg_sel == 4'd15) ? r_pc : r_regs[i_dbg_sel];

endmodule
